// File: rtl/mhd_pkg.sv
// Shared parameters, width rules and FSM state type for the Manhattan ring walker.
package mhd_pkg;

    localparam int COORD_W_DEF = 8;

    // The radius must reach the largest Manhattan distance across the grid.
    function automatic int rad_w(input int coord_w);
        return coord_w + 1;
    endfunction

    // The point count must hold 4*(2^RAD_W-1).
    function automatic int cnt_w(input int coord_w);
        return coord_w + 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DRAIN
    } state_e;

endpackage

// File: rtl/ring_candidate_gen.sv
// Combinational ring stepper: forms the current candidate point, checks it against
// the grid, and computes the next (dx, phase) position in the enumeration.
module ring_candidate_gen
    import mhd_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int RAD_W   = rad_w(COORD_W)
) (
    input  logic [COORD_W-1:0]        cx_i,
    input  logic [COORD_W-1:0]        cy_i,
    input  logic [RAD_W-1:0]          r_i,
    input  logic signed [RAD_W+1:0]   dx_i,
    input  logic                      phase_i,
    output logic [COORD_W-1:0]        x_o,
    output logic [COORD_W-1:0]        y_o,
    output logic                      in_range_o,
    output logic signed [RAD_W+1:0]   dx_next_o,
    output logic                      phase_next_o,
    output logic                      last_o
);

    localparam int SW = RAD_W + 2;

    logic signed [SW-1:0] r_s;
    logic signed [SW-1:0] cx_s;
    logic signed [SW-1:0] cy_s;
    logic signed [SW-1:0] abs_dx;
    logic signed [SW-1:0] h;
    logic signed [SW-1:0] dy;
    logic signed [SW-1:0] x_s;
    logic signed [SW-1:0] y_s;

    always_comb begin
        r_s    = $signed({2'b00, r_i});
        cx_s   = $signed({{(SW-COORD_W){1'b0}}, cx_i});
        cy_s   = $signed({{(SW-COORD_W){1'b0}}, cy_i});
        abs_dx = dx_i[SW-1] ? -dx_i : dx_i;
        h      = r_s - abs_dx;
        dy     = phase_i ? h : -h;
        x_s    = cx_s + dx_i;
        y_s    = cy_s + dy;

        // In range exactly when no sign bit and no bits above the coordinate width.
        in_range_o = (x_s[SW-1:COORD_W] == '0) && (y_s[SW-1:COORD_W] == '0);
        x_o        = x_s[COORD_W-1:0];
        y_o        = y_s[COORD_W-1:0];

        // The apexes (h == 0) have a single point, so their +h phase is skipped.
        if (!phase_i && (h != '0)) begin
            phase_next_o = 1'b1;
            dx_next_o    = dx_i;
        end else begin
            phase_next_o = 1'b0;
            dx_next_o    = dx_i + SW'(1);
        end

        last_o = (dx_i == r_s) && (phase_i || (h == '0));
    end

endmodule

// File: rtl/manhattan_ring_walker.sv
// Streams every in-grid point at Manhattan distance r from (cx,cy) over valid/ready,
// one candidate per cycle, with a run point counter and a done pulse.
module manhattan_ring_walker
    import mhd_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int RAD_W   = rad_w(COORD_W),
    parameter int CNT_W   = cnt_w(COORD_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COORD_W-1:0] cx_i,
    input  logic [COORD_W-1:0] cy_i,
    input  logic [RAD_W-1:0]   radius_i,
    output logic               busy_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [COORD_W-1:0] out_x_o,
    output logic [COORD_W-1:0] out_y_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   point_count_o
);

    localparam int SW = RAD_W + 2;

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   cx_q, cx_d;
    logic [COORD_W-1:0]   cy_q, cy_d;
    logic [RAD_W-1:0]     r_q, r_d;
    logic signed [SW-1:0] dx_q, dx_d;
    logic                 phase_q, phase_d;
    logic                 out_valid_q, out_valid_d;
    logic [COORD_W-1:0]   out_x_q, out_x_d;
    logic [COORD_W-1:0]   out_y_q, out_y_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [COORD_W-1:0]   cand_x;
    logic [COORD_W-1:0]   cand_y;
    logic                 cand_in_range;
    logic signed [SW-1:0] cand_dx_next;
    logic                 cand_phase_next;
    logic                 cand_last;
    logic                 handshake;
    logic                 advance;

    ring_candidate_gen #(
        .COORD_W (COORD_W),
        .RAD_W   (RAD_W)
    ) u_cand (
        .cx_i         (cx_q),
        .cy_i         (cy_q),
        .r_i          (r_q),
        .dx_i         (dx_q),
        .phase_i      (phase_q),
        .x_o          (cand_x),
        .y_o          (cand_y),
        .in_range_o   (cand_in_range),
        .dx_next_o    (cand_dx_next),
        .phase_next_o (cand_phase_next),
        .last_o       (cand_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cx_q        <= '0;
            cy_q        <= '0;
            r_q         <= '0;
            dx_q        <= '0;
            phase_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            r_q         <= r_d;
            dx_q        <= dx_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    // The generator only moves when the output register is empty or draining this cycle.
    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        r_d         = r_q;
        dx_d        = dx_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;

        handshake = out_valid_q && out_ready_i;
        advance   = (state_q == GEN) && (!out_valid_q || out_ready_i);

        if (handshake) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + CNT_W'(1);
        end

        if (advance && cand_in_range) begin
            out_valid_d = 1'b1;
            out_x_d     = cand_x;
            out_y_d     = cand_y;
        end

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the finished run.
                if (start_i && !done_q) begin
                    cx_d    = cx_i;
                    cy_d    = cy_i;
                    r_d     = radius_i;
                    dx_d    = -$signed({2'b00, radius_i});
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (advance) begin
                    dx_d    = cand_dx_next;
                    phase_d = cand_phase_next;
                    if (cand_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != IDLE);
    assign out_valid_o   = out_valid_q;
    assign out_x_o       = out_x_q;
    assign out_y_o       = out_y_q;
    assign done_o        = done_q;
    assign point_count_o = cnt_q;

endmodule

// File: doc/manhattan_ring_walker.md
Name: manhattan_ring_walker

Overview:
- Inverse of the team's combinational Manhattan-distance calculator. It takes a centre (cx,cy) and a radius r. It enumerates every grid point with |x-cx|+|y-cy| == r that lies inside the unsigned COORD_W-bit grid.
- Points stream out one at a time over a valid/ready handshake.
- It feeds the distance calculator (round-trip checking) and the garbled-circuit input generators that need neighbourhood sets.

Parameters:
- COORD_W, 8, coordinate width; grid is 0..2^COORD_W-1 on each axis.
- RAD_W, COORD_W+1, radius width; must hold the maximum Manhattan distance.
- CNT_W, COORD_W+3, width of point_count; must hold 4*(2^RAD_W-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cx  in  COORD_W  centre x; captured on accepted start.
- cy  in  COORD_W  centre y; captured on accepted start.
- radius  in  RAD_W  ring radius; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- out_valid  out  1  out_x/out_y hold a ring point.
- out_ready  in  1  consumer accepts the point when out_valid && out_ready.
- out_x  out  COORD_W  point x.
- out_y  out  COORD_W  point y.
- done  out  1  one-cycle pulse when the enumeration has finished and the last point has been accepted.
- point_count  out  CNT_W  number of points handshaken in the current or most recent run.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the clock edge):
  - state=IDLE.
  - busy=0, out_valid=0, done=0.
  - out_x=0, out_y=0, point_count=0.
- States:
  - IDLE: start=1 captures cx, cy, radius; sets dx=-r, phase=0; clears point_count; goes to GEN.
  - GEN: evaluates one candidate per cycle, and only when the output register is empty or draining (!out_valid || out_ready).
  - DRAIN: enumeration exhausted. When the output register is empty or being accepted this cycle, done pulses next cycle and the state returns to IDLE.
- Enumeration order, internal signed arithmetic RAD_W+2 bits:
  - dx runs from -r up to +r.
  - h = r - |dx|.
  - phase 0: dy = -h. phase 1: dy = +h.
  - When h == 0, phase 1 is skipped (single point).
  - After the last phase for dx=+r, go to DRAIN.
- Candidate test:
  - x = cx+dx, y = cy+dy.
  - The candidate is a point only if 0 <= x,y <= 2^COORD_W-1.
  - Out-of-range candidates are consumed silently. They cost one cycle and produce no output.
- Output register:
  - An in-range candidate loads out_x/out_y and sets out_valid on the next edge.
  - While out_valid && !out_ready, out_x, out_y and out_valid are held stable and the generator stalls.
  - On a handshake with no new point loading that cycle, out_valid drops.
- point_count increments on every handshake. It holds its value after done until the next accepted start.
- Latency: the first candidate is evaluated the cycle after start. If that candidate is in range, out_valid rises 2 cycles after start.
- Throughput: 1 candidate per cycle when out_ready is held high.
- Boundaries:
  - r=0: exactly one point, (cx,cy).
  - Ring wholly outside the grid (e.g. (0,0), r=511): no out_valid; done pulses with point_count=0.
  - start while busy: ignored; no capture, no effect.
  - start in the same cycle as done: ignored; start is accepted only in IDLE, the cycle after done.
  - Reset mid-run: immediate return to IDLE. out_valid drops without a handshake and no done pulse is issued.

Decomposition:
- Shared package mhd_pkg holds:
  - COORD_W default.
  - the derived RAD_W and CNT_W rules.
  - the state enum (IDLE, GEN, DRAIN).
- One natural sub-module, ring_candidate_gen. It is combinational: from (cx, cy, r, dx, phase) it produces the candidate x, y, in_range, and the next (dx, phase, last).
- The top module holds the FSM, the output register and the counter.

Test Plan:
- cx=10, cy=10, r=0, out_ready=1 -> single point (10,10); done; point_count=1.
- cx=10, cy=10, r=1, out_ready=1 -> (9,10), (10,9), (10,11), (11,10) in that order on consecutive cycles; done; point_count=4.
- cx=0, cy=0, r=2 -> (0,2), (1,1), (2,0) only; point_count=3. Also cx=255, cy=255, r=510 -> (0,0) only; point_count=1.
- cx=10, cy=10, r=1, out_ready=0 for 3 cycles at the first point -> out_valid held and (9,10) stable for those cycles; no point lost or duplicated; total 4.
- cx=0, cy=0, r=511 -> out_valid never asserts; done pulses; point_count=0. A start pulse during busy in a concurrent r=5 run leaves that run unchanged.
- Assert rst_n=0 after the 2nd point of an r=3 run -> all outputs return to reset values asynchronously. A new start with r=1 then yields 4 correct points.
